// File: rtl/scroll_defs.sv
// Shared definitions for the scroll controller: FSM state encodings and
// default geometry constants reused by the driver and the bench.
package scroll_defs;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_AUTO   = 2'd1,
    ST_PAUSE  = 2'd2
  } scroll_state_e;

  localparam int unsigned DEF_MSG_LEN     = 16;
  localparam int unsigned DEF_DWELL_TICKS = 8;
  localparam int unsigned DEF_OFF_W       = 4;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for automatic scrolling: counts enabled ticks and flags the
// terminal count (DWELL_TICKS-1); clear and hold control it from the FSM.
module dwell_timer #(
  parameter int unsigned DWELL_TICKS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  input  logic hold,
  output logic terminal
);

  localparam int unsigned CNT_W = $clog2(DWELL_TICKS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_TICKS - 1);

  logic [CNT_W-1:0] dwell_q, dwell_d;

  always_comb begin
    dwell_d = dwell_q;
    if (clear) begin
      dwell_d = '0;
    end else if (enable && !hold) begin
      dwell_d = (dwell_q == LAST) ? '0 : dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end

  assign terminal = (dwell_q == LAST);

endmodule

// File: rtl/scroll_controller.sv
// Scroll window sequencer: manual / auto / pause modes driving the message
// window offset. Define SCROLL_REVERSE_EN to add the dir input (decrementing scroll).
module scroll_controller
  import scroll_defs::*;
#(
  parameter int unsigned MSG_LEN     = DEF_MSG_LEN,
  parameter int unsigned DWELL_TICKS = DEF_DWELL_TICKS,
  parameter int unsigned OFF_W       = DEF_OFF_W
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SCROLL_REVERSE_EN
  input  logic             dir,
`endif
  input  logic             step_pulse,
  input  logic             mode_pulse,
  input  logic             tick_en,
  output logic [OFF_W-1:0] offset,
  output logic             advance,
  output logic             auto_active,
  output logic             paused
);

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(MSG_LEN - 1);

  scroll_state_e    state_q, state_d;
  logic [OFF_W-1:0] offset_q, offset_d;
  logic             advance_q, advance_d;
  logic             auto_active_q, auto_active_d;
  logic             paused_q, paused_d;

  logic dwell_clear, dwell_hold, dwell_term;

  // Dwell only counts in AUTO on a cycle with no competing button event;
  // the step that pauses freezes it, and any mode change restarts it.
  assign dwell_clear = mode_pulse || (state_q == ST_MANUAL);
  assign dwell_hold  = (state_q != ST_AUTO) || step_pulse;

  dwell_timer #(
    .DWELL_TICKS(DWELL_TICKS)
  ) u_dwell (
    .clk     (clk),
    .reset   (reset),
    .enable  (tick_en),
    .clear   (dwell_clear),
    .hold    (dwell_hold),
    .terminal(dwell_term)
  );

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    advance_d = 1'b0;

    unique case (state_q)
      ST_MANUAL: begin
        if (mode_pulse) state_d = ST_AUTO;
        else if (step_pulse) advance_d = 1'b1;
      end
      ST_AUTO: begin
        if (mode_pulse) state_d = ST_MANUAL;
        else if (step_pulse) state_d = ST_PAUSE;
        else if (tick_en && dwell_term) advance_d = 1'b1;
      end
      ST_PAUSE: begin
        if (mode_pulse) state_d = ST_MANUAL;
        else if (step_pulse) state_d = ST_AUTO;
      end
      default: state_d = ST_MANUAL;
    endcase

    // Wrap by explicit compare so non-power-of-2 message lengths work.
    if (advance_d) begin
`ifdef SCROLL_REVERSE_EN
      if (dir) begin
        offset_d = (offset_q == '0) ? LAST_OFF : offset_q - 1'b1;
      end else begin
        offset_d = (offset_q == LAST_OFF) ? '0 : offset_q + 1'b1;
      end
`else
      offset_d = (offset_q == LAST_OFF) ? '0 : offset_q + 1'b1;
`endif
    end

    auto_active_d = (state_d != ST_MANUAL);
    paused_d      = (state_d == ST_PAUSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_MANUAL;
      offset_q      <= '0;
      advance_q     <= 1'b0;
      auto_active_q <= 1'b0;
      paused_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      offset_q      <= offset_d;
      advance_q     <= advance_d;
      auto_active_q <= auto_active_d;
      paused_q      <= paused_d;
    end
  end

  assign offset      = offset_q;
  assign advance     = advance_q;
  assign auto_active = auto_active_q;
  assign paused      = paused_q;

endmodule
